// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The ovf output is only built when SERSUB_OVF_EN is defined.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sersub_state_t;

    localparam int SERSUB_WIDTH = 8;
    localparam int CNT_W        = $clog2(SERSUB_WIDTH + 1);

    // Counter width for an arbitrary WIDTH; sized so it can reach WIDTH without wrapping
    function automatic int sersub_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one shared full-subtractor cell.
// Defining SERSUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int C_W = sersub_cnt_w(WIDTH);
    localparam logic [C_W-1:0] CNT_LAST = C_W'(WIDTH - 1);

    sersub_state_t    state_q, state_d;
    logic [C_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef SERSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fs_d, fs_bo;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERSUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    borrow_d   = bin;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                res_d             = res_q >> 1;
                res_d[WIDTH-1]    = fs_d;
                borrow_d          = fs_bo;
                cnt_d             = cnt_q + C_W'(1);
                if (cnt_q == CNT_LAST) begin
                    bout_d      = fs_bo;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SERSUB_OVF_EN
                    // On the last bit the shifters hold the operand MSBs and fs_d is diff's MSB
                    ovf_d = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ fs_d);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERSUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = res_q;
    assign bout      = bout_q;
`ifdef SERSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed/random/backpressure/reset, WIDTH=3 exhaustive back-to-back.
// Overflow checks are included when SERSUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv8, ir8, ov8, or8, bin8, bout8;
    logic [7:0] a8, b8, d8;
    logic       iv3, ir3, ov3, or3, bin3, bout3;
    logic [2:0] a3, b3, d3;
`ifdef SERSUB_OVF_EN
    logic       ovf8, ovf3;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(or8),
        .diff(d8), .bout(bout8)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
        .a(a3), .b(b3), .bin(bin3), .out_valid(ov3), .out_ready(or3),
        .diff(d3), .bout(bout3)
`ifdef SERSUB_OVF_EN
        , .ovf(ovf3)
`endif
    );

    // Reference: plain integer arithmetic, {borrow, diff}
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int t;
        t = int'(a) - int'(b) - int'(bi);
        return {(t < 0), t[7:0]};
    endfunction

    function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int t;
        t = int'($signed(a)) - int'($signed(b)) - int'(bi);
        return (t > 127) || (t < -128);
    endfunction

    function automatic logic [4:0] ref3(input logic [2:0] a, input logic [2:0] b, input logic bi);
        int t, s;
        t = int'(a) - int'(b) - int'(bi);
        s = int'($signed(a)) - int'($signed(b)) - int'(bi);
        return {((s > 3) || (s < -4)), (t < 0), t[2:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one WIDTH=8 operation and returns the result; lat = -1 on timeout
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo, output logic ov, output int lat);
        int n;
        d = '0; bo = 1'b0; ov = 1'b0; lat = -1;
        n = 0;
        while (!ir8 && n < 30) begin tick(); n++; end
        if (!ir8) return;
        iv8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
        tick();
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < 30) begin tick(); n++; end
        if (!ov8) return;
        lat = n;
        d = d8; bo = bout8;
`ifdef SERSUB_OVF_EN
        ov = ovf8;
`endif
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({ir8, ov8, d8, bout8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset8: got ir=%b ov=%b diff=%h bout=%b, want ir=1 ov=0 diff=00 bout=0", ir8, ov8, d8, bout8);
        end
        tests++;
        if ({ir3, ov3, d3, bout3} !== {1'b1, 1'b0, 3'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset3: got ir=%b ov=%b diff=%h bout=%b, want ir=1 ov=0 diff=0 bout=0", ir3, ov3, d3, bout3);
        end
`ifdef SERSUB_OVF_EN
        tests++;
        if (ovf8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: got %b want 0", ovf8);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed;
        logic [7:0] va [4] = '{8'h35, 8'h00, 8'h80, 8'h7F};
        logic [7:0] vb [4] = '{8'h12, 8'h01, 8'h01, 8'hFF};
        logic [7:0] ed [4] = '{8'h23, 8'hFF, 8'h7F, 8'h80};
        logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run8(va[i], vb[i], 1'b0, d, bo, ov, lat);
            tests++;
            if (lat !== 8) begin
                fails++;
                $display("FAIL dir_latency[%0d]: got %0d cycles want 8", i, lat);
            end
            tests++;
            if ({bo, d} !== {eb[i], ed[i]}) begin
                fails++;
                $display("FAIL dir_result[%0d]: got diff=%h bout=%b want diff=%h bout=%b", i, d, bo, ed[i], eb[i]);
            end
`ifdef SERSUB_OVF_EN
            tests++;
            if (ov !== eo[i]) begin
                fails++;
                $display("FAIL dir_ovf[%0d]: got %b want %b", i, ov, eo[i]);
            end
`else
            if (ov !== 1'b0 && eo[i] === 1'bx) fails++;
`endif
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b, d;
        logic       bi, bo, ov;
        logic [8:0] e;
        int         lat;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
            if (i == 0) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
            if (i == 1) begin a = 8'hFF; b = 8'h00; bi = 1'b0; end
            e = ref8(a, b, bi);
            run8(a, b, bi, d, bo, ov, lat);
            tests++;
            if ({bo, d} !== e || lat != 8) begin
                fails++;
                $display("FAIL rand[%0d] %h-%h-%b: got diff=%h bout=%b lat=%0d want diff=%h bout=%b lat=8",
                         i, a, b, bi, d, bo, lat, e[7:0], e[8]);
            end
`ifdef SERSUB_OVF_EN
            tests++;
            if (ov !== ref_ovf8(a, b, bi)) begin
                fails++;
                $display("FAIL rand_ovf[%0d]: got %b want %b", i, ov, ref_ovf8(a, b, bi));
            end
`endif
        end
    endtask

    task automatic test_backpressure;
        int n;
        n = 0;
        while (!ir8 && n < 30) begin tick(); n++; end
        iv8 = 1'b1; a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0;
        tick();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 30) begin tick(); n++; end
        tests++;
        if (!ov8) begin
            fails++;
            $display("FAIL bp_timeout: out_valid never rose, got 0 want 1");
        end
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({ov8, ir8, d8, bout8} !== {1'b1, 1'b0, 8'h23, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b diff=%h bout=%b want ov=1 ir=0 diff=23 bout=0",
                         i, ov8, ir8, d8, bout8);
            end
        end
        or8 = 1'b1;
        tick();
        iv8 = 1'b0; or8 = 1'b0;
        tests++;
        if ({ov8, ir8} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
        end
        tick();
        tests++;
        if ({ov8, ir8} !== 2'b01) begin
            fails++;
            $display("FAIL bp_no_accept: got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        iv8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        tests++;
        if ({ov8, ir8, d8, bout8} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL midrun_reset: got ov=%b ir=%b diff=%h bout=%b want ov=0 ir=1 diff=00 bout=0",
                     ov8, ir8, d8, bout8);
        end
        rst_n = 1'b1;
        tick();
        run8(8'h10, 8'h01, 1'b1, d, bo, ov, lat);
        tests++;
        if ({bo, d} !== {1'b0, 8'h0E} || lat != 8) begin
            fails++;
            $display("FAIL midrun_after: got diff=%h bout=%b lat=%0d want diff=0e bout=0 lat=8", d, bo, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_q[$];
        logic [4:0] e;
        int issued, got, cyc;
        issued = 0; got = 0; cyc = 0;
        or3 = 1'b1;
        while (got < 128 && cyc < 1200) begin
            if (ov3) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_spurious: got out_valid=1 want no pending result");
                end else begin
                    e = exp_q.pop_front();
`ifdef SERSUB_OVF_EN
                    if ({ovf3, bout3, d3} !== e) begin
`else
                    if ({bout3, d3} !== e[3:0]) begin
`endif
                        fails++;
                        $display("FAIL b2b[%0d]: got diff=%0d bout=%b want diff=%0d bout=%b ovf=%b",
                                 got, d3, bout3, e[2:0], e[3], e[4]);
                    end
                end
                got++;
            end
            iv3 = (issued < 128);
            if (ir3 && issued < 128) begin
                {a3, b3, bin3} = 7'(issued);
                exp_q.push_back(ref3(a3, b3, bin3));
                issued++;
            end
            tick();
            cyc++;
        end
        iv3 = 1'b0; or3 = 1'b0;
        tests++;
        if (got != 128 || cyc > 128 * 5 + 8) begin
            fails++;
            $display("FAIL b2b_throughput: got %0d results in %0d cycles want 128 in <= %0d", got, cyc, 128 * 5 + 8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        iv3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
